// File: rtl/uint_to_fp32_pkg.sv
// Shared types and IEEE-754 single-precision constants for uint_to_fp32.
// Optional macro UINT_TO_FP32_SIGNED_EN (consumed by rtl/uint_to_fp32.sv)
// switches the input to two's complement.
package uint_to_fp32_pkg;

    // Converter control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned FP_BIAS   = 127;
    localparam int unsigned FP_EXP_W  = 8;
    localparam int unsigned FP_FRAC_W = 23;
    localparam logic [31:0] FP_ZERO   = 32'h0;

    // Biased exponent loaded at accept: value of the MSB position of an IN_W-bit magnitude
    function automatic logic [FP_EXP_W-1:0] exp_init(input int unsigned in_w);
        return FP_EXP_W'(FP_BIAS + in_w - 1);
    endfunction

endpackage

// File: rtl/uint_to_fp32_if.sv
// Handshake bundle for uint_to_fp32: input valid/ready/data, output
// valid/ready/result and a busy flag.  Master = producer/consumer side,
// slave = converter side.
interface uint_to_fp32_if #(
    parameter int unsigned IN_W = 8
);

    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_fp;
    logic            busy;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_fp,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_fp,
        output busy
    );

endinterface

// File: rtl/uint_to_fp32_pack.sv
// fp32_pack: assembles a single-precision word from sign, biased exponent and
// a left-normalized IN_W-bit magnitude (hidden bit in mag[IN_W-1]).
// A magnitude whose hidden bit is clear can only be zero and packs as +0.
module fp32_pack
    import uint_to_fp32_pkg::*;
#(
    parameter int unsigned IN_W = 8
) (
    input  logic                sign,
    input  logic [FP_EXP_W-1:0] exp,
    input  logic [IN_W-1:0]     mag,
    output logic [31:0]         fp
);

    logic [FP_FRAC_W:0] aligned;

    // Left-align the magnitude to 24 bits so the fraction is the 23 bits below the hidden bit
    always_comb begin
        aligned = (FP_FRAC_W + 1)'(mag) << (FP_FRAC_W + 1 - IN_W);
        if (aligned[FP_FRAC_W]) begin
            fp = {sign, exp, aligned[FP_FRAC_W-1:0]};
        end else begin
            fp = FP_ZERO;
        end
    end

endmodule

// File: rtl/uint_to_fp32.sv
// uint_to_fp32: multi-cycle integer to IEEE-754 single-precision converter.
// One value is accepted in IDLE, normalized one bit per cycle in NORM and
// held in DONE until the consumer takes it.
// Macro UINT_TO_FP32_SIGNED_EN: treat in_data as two's complement.
module uint_to_fp32
    import uint_to_fp32_pkg::*;
#(
    parameter int unsigned IN_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    uint_to_fp32_if.slave bus
);

    localparam logic [FP_EXP_W-1:0] EXP_INIT = exp_init(IN_W);

    state_t                state;
    state_t                state_next;
    logic                  accept;
    logic [IN_W-1:0]       mag;
    logic [FP_EXP_W-1:0]   exp;
    logic                  sign;
    logic [IN_W-1:0]       in_mag;
    logic                  in_sign;
    logic [31:0]           out_fp;
    logic [31:0]           packed_fp;

`ifdef UINT_TO_FP32_SIGNED_EN
    // Two's complement input: magnitude of the most negative value still fits IN_W bits unsigned
    always_comb begin
        in_sign = bus.in_data[IN_W-1];
        in_mag  = in_sign ? -bus.in_data : bus.in_data;
    end

    // Sign is latched together with the magnitude at accept
    always_ff @(posedge clk) begin
        if (rst) begin
            sign <= 1'b0;
        end else if (accept) begin
            sign <= in_sign;
        end
    end
`else
    // Unsigned input: positive results only
    always_comb begin
        in_sign = 1'b0;
        in_mag  = bus.in_data;
        sign    = in_sign;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and accept decision
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    state_next = (in_mag == '0) ? DONE : NORM;
                end
            end
            NORM: begin
                if (mag[IN_W-1]) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Magnitude shifter, exponent counter and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            mag    <= '0;
            exp    <= '0;
            out_fp <= FP_ZERO;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mag <= in_mag;
                        exp <= EXP_INIT;
                        if (in_mag == '0) begin
                            out_fp <= FP_ZERO;
                        end
                    end
                end
                NORM: begin
                    if (mag[IN_W-1]) begin
                        out_fp <= packed_fp;
                    end else begin
                        mag <= {mag[IN_W-2:0], 1'b0};
                        exp <= exp - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    fp32_pack #(
        .IN_W(IN_W)
    ) u_pack (
        .sign(sign),
        .exp (exp),
        .mag (mag),
        .fp  (packed_fp)
    );

    // Handshake outputs decoded straight from the state register
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.busy      = (state != IDLE);
        bus.out_fp    = out_fp;
    end

endmodule
